// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: scans one digit per SCAN_DIV cycles,
// decodes through a single shared table, and drives registered active-low pins.
// Input codes are snapshotted once per frame so a scan never mixes two values.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           fc;
  logic                    ph;
  logic                    first;
  logic [4*NUM_DIGITS-1:0] snap_dig;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blink;

  logic                    step;
  logic                    load;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   sup;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    cur_sup;
  logic [7:0]              seg_nxt;

  // Segment pattern a..g (active-low) for each 4-bit display code.
  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      4'd10:   seg7 = 7'b1111111;
      4'd11:   seg7 = 7'b1111110;
      4'd12:   seg7 = 7'b0110001;
      4'd13:   seg7 = 7'b1000010;
      4'd14:   seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign step = (cnt == CNT_LAST);
  assign load = first | (step & (idx == IDX_LAST));

  // Leading-zero mask: walk down from the top digit while every code seen is 0.
  always_comb begin
    upper_zero = 1'b1;
    sup        = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (snap_dig[4*i +: 4] == 4'd0);
      sup[i]     = blank_lz & upper_zero;
    end
  end

  // Select the digit under idx and form the next pin values.
  always_comb begin
    cur_code  = 4'd0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_sup   = 1'b0;
    an_nxt    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = snap_dig[4*i +: 4];
        cur_dp    = snap_dp[i];
        cur_blink = snap_blink[i];
        cur_sup   = sup[i];
        an_nxt[i] = 1'b0;
      end
    end
    if (cur_sup | (cur_blink & ph))
      seg_nxt = 8'hFF;
    else
      seg_nxt = {seg7(cur_code), ~cur_dp};
  end

  // Scan position, per-frame input snapshot and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      fc         <= '0;
      ph         <= 1'b0;
      first      <= 1'b1;
      snap_dig   <= {NUM_DIGITS{4'hA}};
      snap_dp    <= '0;
      snap_blink <= '0;
    end else begin
      first <= 1'b0;
      if (step) begin
        cnt <= '0;
        if (idx == IDX_LAST)
          idx <= '0;
        else
          idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        snap_dig   <= digits;
        snap_dp    <= dp_en;
        snap_blink <= blink_en;
        if (!first) begin
          if (fc == FC_LAST) begin
            fc <= '0;
            ph <= ~ph;
          end else begin
            fc <= fc + 1'b1;
          end
        end
      end
    end
  end

  // Registered pin drivers, trailing idx by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n       <= 8'hFF;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= seg_nxt;
      an_n        <= an_nxt;
      frame_start <= load;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with 4 digits, 4 cycles per digit, 2 frames per blink half.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits;
  logic [3:0]    dp_en;
  logic [3:0]    blink_en;
  logic          blank_lz;
  logic [7:0]    seg_n;
  logic [3:0]    an_n;
  logic          frame_start;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_en(dp_en), .blink_en(blink_en),
    .blank_lz(blank_lz), .seg_n(seg_n), .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [15:0]      dig;
    logic [3:0]       dp;
    logic [3:0]       bl;
    logic             blz;
    logic [3:0][7:0]  exp;
  } vec_t;

  typedef struct {
    string           name;
    logic [3:0][7:0] exp;
  } sb_t;

  vec_t       vl[$];
  sb_t        sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       mon_en = 1'b0;
  int         start_pos = 0;
  logic [6:0] seg7_tab [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [15:0] dg, input logic [3:0] dp,
                              input logic [3:0] bl, input logic blz, input logic [31:0] ex);
    vec_t v;
    v.name = nm; v.dig = dg; v.dp = dp; v.bl = bl; v.blz = blz; v.exp = ex;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    digits = v.dig; dp_en = v.dp; blink_en = v.bl;
  endtask

  task automatic push(input vec_t v);
    sb_t s;
    s.name = v.name; s.exp = v.exp;
    sbq.push_back(s);
  endtask

  task automatic wait_fs(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 40);
    if (frame_start !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s frame_start timeout: got 0, required 1 within 40 cycles", nm);
    end
  endtask

  task automatic wait_an(input logic [3:0] want, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (an_n !== want && n < 40);
    if (an_n !== want) begin
      n_cmp++; n_bad++;
      $display("FAIL %s an_n timeout: got %b, required %b", nm, an_n, want);
    end
  endtask

  // Each load pops the record of the inputs it captured; the next 16 samples are checked.
  initial begin
    sb_t        cur;
    int         pos;
    int         d;
    logic       active;
    logic [3:0] an_req;
    active = 1'b0;
    pos = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        active = 1'b0;
      end else begin
        if (active) begin
          d = pos / SD;
          an_req = ~(4'b0001 << d);
          chk($sformatf("%s an_n pos%0d", cur.name, pos), 32'(an_n), 32'(an_req));
          chk($sformatf("%s seg_n d%0d pos%0d", cur.name, d, pos), 32'(seg_n), 32'(cur.exp[d]));
          chk($sformatf("%s frame_start pos%0d", cur.name, pos), 32'(frame_start), 32'(pos == 15));
          pos++;
          if (pos == ND * SD) active = 1'b0;
        end
        if (frame_start === 1'b1 && sbq.size() > 0) begin
          cur = sbq.pop_front();
          if (start_pos == 1) begin
            chk("first edge an_n", 32'(an_n), 32'(4'b1110));
            chk("first edge seg_n", 32'(seg_n), 32'(8'hFF));
          end
          pos = start_pos;
          start_pos = 0;
          active = 1'b1;
        end
      end
    end
  end

  task automatic reset_hold(input string nm);
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk({nm, " reset seg_n"}, 32'(seg_n), 32'(8'hFF));
    chk({nm, " reset an_n"}, 32'(an_n), 32'(4'b1111));
    chk({nm, " reset frame_start"}, 32'(frame_start), 32'(0));
  endtask

  task automatic release_with();
    apply(vl[0]);
    blank_lz = vl[0].blz;
    sbq.delete();
    push(vl[0]);
    start_pos = 1;
    mon_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic run_list();
    int n = vl.size();
    for (int k = 0; k < n; k++) begin
      wait_fs(vl[k].name);
      blank_lz = vl[k].blz;
      if (k + 1 < n) begin
        apply(vl[k+1]);
        push(vl[k+1]);
      end
    end
    wait_fs("list end");
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    seg7_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                 7'b0000000, 7'b0000100, 7'b1111111, 7'b1111110,
                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst = 1'b1;
    digits = 16'h0; dp_en = 4'h0; blink_en = 4'h0; blank_lz = 1'b0;

    // Reset and the first two frames of 1234.
    reset_hold("init");
    vl.delete();
    vl.push_back(mk("f1_1234", 16'h1234, 4'h0, 4'h0, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}));
    vl.push_back(mk("f2_1234", 16'h1234, 4'h0, 4'h0, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}));
    release_with();
    run_list();

    // Code table on digit 0 with its dp lit, then leading-zero blanking cases.
    vl.delete();
    for (int c = 0; c < 16; c++)
      vl.push_back(mk($sformatf("code%0d", c), {12'h000, 4'(c)}, 4'b0001, 4'h0, 1'b0,
                      {8'h03, 8'h03, 8'h03, {seg7_tab[c], 1'b0}}));
    vl.push_back(mk("lz_0050",   16'h0050, 4'h0, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'h49, 8'h03}));
    vl.push_back(mk("lz_0000",   16'h0000, 4'h0, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}));
    vl.push_back(mk("nolz_0000", 16'h0000, 4'h0, 4'h0, 1'b0, {8'h03, 8'h03, 8'h03, 8'h03}));
    vl.push_back(mk("lz_0102",   16'h0102, 4'h0, 4'h0, 1'b1, {8'hFF, 8'h9F, 8'h03, 8'h25}));
    vl.push_back(mk("lz_dp_0005", 16'h0005, 4'hF, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h48}));
    vl.push_back(mk("lz_1234",   16'h1234, 4'h0, 4'h0, 1'b1, {8'h9F, 8'h25, 8'h0D, 8'h99}));
    apply(vl[0]);
    push(vl[0]);
    run_list();

    // Blink on digit 1: frames 1-2 lit, 3-4 dark, 5-6 lit, counted from reset.
    reset_hold("blink");
    vl.delete();
    for (int f = 1; f <= 6; f++)
      vl.push_back(mk($sformatf("blink_f%0d", f), 16'h8888, 4'h0, 4'b0010, 1'b0,
                      {8'h01, 8'h01, ((f == 3 || f == 4) ? 8'hFF : 8'h01), 8'h01}));
    release_with();
    run_list();

    // Input change mid-frame must not disturb the frame on display.
    vl.delete();
    vl.push_back(mk("coh_1111", 16'h1111, 4'h0, 4'h0, 1'b0, {8'h9F, 8'h9F, 8'h9F, 8'h9F}));
    vl.push_back(mk("coh_2222", 16'h2222, 4'h0, 4'h0, 1'b0, {8'h25, 8'h25, 8'h25, 8'h25}));
    apply(vl[0]);
    push(vl[0]);
    wait_fs("coh load");
    wait_an(4'b1101, "coh idx1");
    apply(vl[1]);
    push(vl[1]);
    wait_fs("coh next");
    wait_fs("coh end");
    #1;

    // Asynchronous reset while digit 2 is being driven.
    wait_an(4'b1011, "async");
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async seg_n", 32'(seg_n), 32'(8'hFF));
    chk("async an_n", 32'(an_n), 32'(4'b1111));
    chk("async frame_start", 32'(frame_start), 32'(0));
    repeat (2) @(negedge clk);
    vl.delete();
    vl.push_back(mk("post_rst_1234", 16'h1234, 4'h0, 4'h0, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}));
    release_with();
    run_list();

    chk("scoreboard drained", 32'(sbq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
